batch_sample_ctrl: RTL and testbench

BATCH_SAMPLE_CTRL -- requirements
Module: batch_sample_ctrl

---
 rtl/batch_sample_ctrl_if.sv | 33 +++
 rtl/batch_sample_ctrl.sv | 149 ++++++++++++++
 tb/tb_batch_sample_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/batch_sample_ctrl_if.sv
// Sample-in / RAM-port bundle for batch_sample_ctrl.
// The controller drives the bus through "master"; the sample source and RAM observe through "slave".
interface batch_sample_ctrl_if #(
    parameter int N         = 4,
    parameter int DSR       = 12,
    parameter int SEG_DEPTH = 19,
    parameter int N_SECT    = 4,
    parameter int N_RD      = 3
);
    localparam int AW = $clog2(N_SECT * SEG_DEPTH);
    localparam int W  = N * DSR;
    localparam int SW = $clog2(N_SECT);

    logic [N-1:0]       in;
    logic               in_valid;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [W-1:0]       wr_data;
    logic [N_RD*AW-1:0] rd_addr;
    logic               seg_done;
    logic [SW-1:0]      seg_idx;
    logic               primed;

    modport master (
        input  in, in_valid,
        output wr_en, wr_addr, wr_data, rd_addr, seg_done, seg_idx, primed
    );

    modport slave (
        output in, in_valid,
        input  wr_en, wr_addr, wr_data, rd_addr, seg_done, seg_idx, primed
    );
endinterface

// File: rtl/batch_sample_ctrl.sv
// Packs N-bit samples into DSR-sample words, writes them round a segmented RAM ring and
// generates lagging read addresses. Optional input stalling via macro SCTRL_STALL_EN.
module batch_sample_ctrl #(
    parameter int            N         = 4,
    parameter int            DSR       = 12,
    parameter int            SEG_DEPTH = 19,
    parameter int            N_SECT    = 4,
    parameter int            N_RD      = 3,
    parameter logic [N_RD-1:0] RD_DIR  = 3'b010
) (
    input  logic                clk,
    input  logic                rst,
    batch_sample_ctrl_if.master bus
);
    localparam int AW = $clog2(N_SECT * SEG_DEPTH);
    localparam int W  = N * DSR;
    localparam int SW = $clog2(N_SECT);
    localparam int CW = (DSR > 1) ? $clog2(DSR) : 1;
    localparam int OW = (SEG_DEPTH > 1) ? $clog2(SEG_DEPTH) : 1;
    localparam int FW = $clog2(N_RD + 1);

    typedef enum logic {FILL, RUN} state_t;

    logic               accept;
    logic               word_done;
    logic               seg_last;
    logic [CW-1:0]      sub_cnt_q;
    logic [W-1:0]       pack_q;
    logic [W-1:0]       pack_d;
    logic [AW-1:0]      wr_ptr_q;
    logic [SW-1:0]      seg_q;
    logic [OW-1:0]      off_q;

    logic               wr_en_q;
    logic [AW-1:0]      wr_addr_q;
    logic [W-1:0]       wr_data_q;
    logic [N_RD*AW-1:0] rd_addr_q;
    logic [N_RD*AW-1:0] rd_addr_d;
    logic               seg_done_q;
    logic [SW-1:0]      seg_idx_q;
    logic               primed_q;
    state_t             state_q;
    logic [FW-1:0]      fill_cnt_q;

`ifdef SCTRL_STALL_EN
    assign accept = bus.in_valid;
`else
    assign accept = bus.in_valid | 1'b1;
`endif

    assign word_done = accept && (sub_cnt_q == CW'(DSR - 1));
    assign seg_last  = (off_q == OW'(SEG_DEPTH - 1));

    // Each slot of the packed word only loads when the sample counter points at it.
    for (genvar gi = 0; gi < DSR; gi++) begin : g_slot
        assign pack_d[gi*N +: N] = (accept && (sub_cnt_q == CW'(gi))) ? bus.in : pack_q[gi*N +: N];
    end

    // Port k trails the writer by k+1 segments; descending ports walk their segment backwards.
    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
        logic [SW:0]   seg_sum;
        logic [SW-1:0] rd_seg;
        logic [AW-1:0] rd_off;
        logic [AW-1:0] rd_base;

        assign seg_sum = {1'b0, seg_q} + (SW + 1)'(N_SECT - 1 - gi);
        assign rd_seg  = (seg_sum >= (SW + 1)'(N_SECT)) ? SW'(seg_sum - (SW + 1)'(N_SECT))
                                                        : SW'(seg_sum);
        assign rd_off  = RD_DIR[gi] ? (AW'(SEG_DEPTH - 1) - AW'(off_q)) : AW'(off_q);
        assign rd_base = AW'(int'(rd_seg) * SEG_DEPTH);
        assign rd_addr_d[gi*AW +: AW] = primed_q ? (rd_base + rd_off) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt_q  <= '0;
            pack_q     <= '0;
            wr_ptr_q   <= '0;
            seg_q      <= '0;
            off_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            seg_done_q <= 1'b0;
            seg_idx_q  <= '0;
        end else begin
            wr_en_q    <= 1'b0;
            seg_done_q <= 1'b0;
            if (accept) begin
                pack_q    <= pack_d;
                sub_cnt_q <= word_done ? '0 : sub_cnt_q + 1'b1;
            end
            if (word_done) begin
                wr_en_q    <= 1'b1;
                wr_addr_q  <= wr_ptr_q;
                wr_data_q  <= pack_d;
                rd_addr_q  <= rd_addr_d;
                seg_done_q <= seg_last;
                if (seg_last) begin
                    seg_idx_q <= seg_q;
                    off_q     <= '0;
                    // The ring end always coincides with a segment end, so one branch covers both.
                    if (seg_q == SW'(N_SECT - 1)) begin
                        seg_q    <= '0;
                        wr_ptr_q <= '0;
                    end else begin
                        seg_q    <= seg_q + 1'b1;
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                end else begin
                    off_q    <= off_q + 1'b1;
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            primed_q   <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (seg_done_q) begin
                        if (fill_cnt_q == FW'(N_RD - 1)) begin
                            state_q  <= RUN;
                            primed_q <= 1'b1;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + 1'b1;
                        end
                    end
                end
                RUN: primed_q <= 1'b1;
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.seg_done = seg_done_q;
    assign bus.seg_idx  = seg_idx_q;
    assign bus.primed   = primed_q;
endmodule

// File: tb/tb_batch_sample_ctrl.sv
// Directed bench for batch_sample_ctrl: a sample-stream model checks every cycle,
// literal expectations pin the write sequence, reset behaviour and stalling.
module tb_batch_sample_ctrl;
    localparam int N         = 4;
    localparam int DSR       = 12;
    localparam int SEG_DEPTH = 19;
    localparam int N_SECT    = 4;
    localparam int N_RD      = 3;
    localparam logic [2:0] RD_DIR = 3'b010;
    localparam int AW    = 7;
    localparam int W     = 48;
    localparam int DEPTH = N_SECT * SEG_DEPTH;
    localparam int LOGSZ = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;

    batch_sample_ctrl_if #(.N(N), .DSR(DSR), .SEG_DEPTH(SEG_DEPTH), .N_SECT(N_SECT), .N_RD(N_RD)) bus ();

    batch_sample_ctrl #(
        .N(N), .DSR(DSR), .SEG_DEPTH(SEG_DEPTH), .N_SECT(N_SECT), .N_RD(N_RD), .RD_DIR(RD_DIR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Stream model: accepted samples build a word; the k-th word since reset goes to k mod DEPTH.
    logic [W-1:0]       acc_word = '0;
    int                 acc_n    = 0;
    int                 wc       = 0;
    int                 seg_cnt  = 0;
    int                 cyc      = 0;
    bit                 primed_vis = 1'b0;
    bit                 new_primed;
    bit                 took;
    int                 m_addr, m_seg, m_off, m_rs, m_ra;
    logic               exp_wr_en = 1'b0;
    logic [AW-1:0]      exp_wr_addr = '0;
    logic [W-1:0]       exp_wr_data = '0;
    logic               exp_seg_done = 1'b0;
    logic [1:0]         exp_seg_idx = '0;
    logic [N_RD*AW-1:0] exp_rd = '0;

    int                 log_n = 0;
    int                 log_cyc  [LOGSZ];
    logic [AW-1:0]      log_addr [LOGSZ];
    logic [W-1:0]       log_data [LOGSZ];
    logic               log_sd   [LOGSZ];
    logic [1:0]         log_si   [LOGSZ];
    logic               log_pr   [LOGSZ];
    logic [N_RD*AW-1:0] log_rd   [LOGSZ];

    // Inputs change at negedge+1, so at negedge they still hold what the last posedge sampled.
    always @(negedge clk) begin
        if (rst) begin
            acc_word = '0; acc_n = 0; wc = 0; seg_cnt = 0; cyc = 0; primed_vis = 1'b0;
            exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0;
            exp_seg_done = 1'b0; exp_seg_idx = '0; exp_rd = '0;
            log_n = 0;
        end else begin
            cyc++;
            exp_wr_en    = 1'b0;
            exp_seg_done = 1'b0;
            new_primed   = (seg_cnt >= N_RD);
`ifdef SCTRL_STALL_EN
            took = bus.in_valid;
`else
            took = 1'b1;
`endif
            if (took) begin
                acc_word[acc_n*N +: N] = bus.in;
                acc_n++;
                if (acc_n == DSR) begin
                    m_addr = wc % DEPTH;
                    m_seg  = m_addr / SEG_DEPTH;
                    m_off  = m_addr % SEG_DEPTH;
                    exp_wr_en   = 1'b1;
                    exp_wr_addr = AW'(m_addr);
                    exp_wr_data = acc_word;
                    if (m_off == SEG_DEPTH - 1) begin
                        exp_seg_done = 1'b1;
                        exp_seg_idx  = 2'(m_seg);
                        seg_cnt++;
                    end
                    for (int k = 0; k < N_RD; k++) begin
                        m_rs = (m_seg - 1 - k + N_SECT) % N_SECT;
                        m_ra = m_rs * SEG_DEPTH + (RD_DIR[k] ? (SEG_DEPTH - 1 - m_off) : m_off);
                        exp_rd[k*AW +: AW] = primed_vis ? AW'(m_ra) : '0;
                    end
                    wc++;
                    acc_n = 0;
                    acc_word = '0;
                end
            end
            primed_vis = new_primed;

            check("wr_en", 64'(bus.wr_en), 64'(exp_wr_en));
            check("seg_done", 64'(bus.seg_done), 64'(exp_seg_done));
            check("primed", 64'(bus.primed), 64'(primed_vis));
            check("rd_addr", 64'(bus.rd_addr), 64'(exp_rd));
            if (exp_wr_en) begin
                check("wr_addr", 64'(bus.wr_addr), 64'(exp_wr_addr));
                check("wr_data", 64'(bus.wr_data), 64'(exp_wr_data));
            end
            if (exp_seg_done) check("seg_idx", 64'(bus.seg_idx), 64'(exp_seg_idx));

            if (bus.wr_en && log_n < LOGSZ) begin
                log_cyc[log_n]  = cyc;
                log_addr[log_n] = bus.wr_addr;
                log_data[log_n] = bus.wr_data;
                log_sd[log_n]   = bus.seg_done;
                log_si[log_n]   = bus.seg_idx;
                log_pr[log_n]   = bus.primed;
                log_rd[log_n]   = bus.rd_addr;
                log_n++;
            end
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic vld);
        @(negedge clk);
        #1;
        bus.in = v;
        bus.in_valid = vld;
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    logic [N-1:0] r;

    initial begin
        bus.in = '0;
        bus.in_valid = 1'b1;
        #1;
        check("reset_outputs", 64'({bus.wr_en, bus.wr_addr, bus.wr_data, bus.seg_done,
                                    bus.seg_idx, bus.primed}), 64'd0);
        check("reset_rd_addr", 64'(bus.rd_addr), 64'd0);
        repeat (2) @(negedge clk);

        // Epoch 1: 12 x 4'hA, a 0..11 ramp, then random samples up to 80 words.
        #1; rst = 1'b0; bus.in = 4'hA; bus.in_valid = 1'b1;
        repeat (11) drive(4'hA, 1'b1);
        for (int j = 0; j < DSR; j++) drive(N'(j), 1'b1);
        for (int j = 0; j < 78 * DSR; j++) begin
            r = N'($urandom_range(0, 15));
            drive(r, 1'b1);
        end
        settle();
        check("epoch1_write_count", 64'(log_n), 64'd80);
        check("first_wr_cycle", 64'(log_cyc[0]), 64'd12);
        check("first_wr_addr", 64'(log_addr[0]), 64'd0);
        check("first_wr_data", 64'(log_data[0]), 64'hAAAAAAAAAAAA);
        check("second_wr_cycle", 64'(log_cyc[1]), 64'd24);
        check("ramp_wr_data", 64'(log_data[1]), 64'hBA9876543210);
        check("w18_seg_done", 64'(log_sd[17]), 64'd0);
        check("w19_seg_done", 64'(log_sd[18]), 64'd1);
        check("w19_seg_idx", 64'(log_si[18]), 64'd0);
        check("w19_addr", 64'(log_addr[18]), 64'd18);
        check("w57_primed", 64'(log_pr[56]), 64'd0);
        check("w57_rd_addr", 64'(log_rd[56]), 64'd0);
        check("w58_primed", 64'(log_pr[57]), 64'd1);
        check("w58_addr", 64'(log_addr[57]), 64'd57);
        check("w58_rd_port0", 64'(log_rd[57][0*AW +: AW]), 64'd38);
        check("w58_rd_port1", 64'(log_rd[57][1*AW +: AW]), 64'd37);
        check("w58_rd_port2", 64'(log_rd[57][2*AW +: AW]), 64'd0);
        check("w76_addr", 64'(log_addr[75]), 64'd75);
        check("w76_seg_done", 64'(log_sd[75]), 64'd1);
        check("w76_seg_idx", 64'(log_si[75]), 64'd3);
        check("w77_addr", 64'(log_addr[76]), 64'd0);

        // Epoch 2: reset part-way through a word.
        repeat (5) drive(4'h7, 1'b1);
        @(negedge clk);
        #1; rst = 1'b1;
        #1;
        check("midword_reset_outputs", 64'({bus.wr_en, bus.wr_addr, bus.wr_data, bus.seg_done,
                                            bus.seg_idx, bus.primed}), 64'd0);
        check("midword_reset_rd_addr", 64'(bus.rd_addr), 64'd0);
        @(negedge clk);
        #1; rst = 1'b0; bus.in = 4'hB; bus.in_valid = 1'b1;
        for (int j = 1; j < DSR; j++) drive(N'(11 - j), 1'b1);
        settle();
        check("post_reset_wr_cycle", 64'(log_cyc[0]), 64'd12);
        check("post_reset_wr_addr", 64'(log_addr[0]), 64'd0);
        check("post_reset_wr_data", 64'(log_data[0]), 64'h0123456789AB);
        check("post_reset_primed", 64'(log_pr[0]), 64'd0);

        // Epoch 3: in_valid gaps mid-word.
        @(negedge clk);
        #1; rst = 1'b1;
        @(negedge clk);
`ifdef SCTRL_STALL_EN
        #1; rst = 1'b0; bus.in = 4'h0; bus.in_valid = 1'b1;
        for (int j = 1; j < 5; j++) drive(N'(j), 1'b1);
        repeat (3) drive(4'hF, 1'b0);
        for (int j = 5; j < DSR; j++) drive(N'(j), 1'b1);
        drive(4'h0, 1'b0);
        settle();
        check("stall_wr_cycle", 64'(log_cyc[0]), 64'd15);
        check("stall_wr_data", 64'(log_data[0]), 64'hBA9876543210);
`else
        #1; rst = 1'b0; bus.in = 4'h0; bus.in_valid = 1'b0;
        for (int j = 1; j < DSR; j++) drive(N'(j), 1'b0);
        settle();
        check("novalid_wr_cycle", 64'(log_cyc[0]), 64'd12);
        check("novalid_wr_data", 64'(log_data[0]), 64'hBA9876543210);
`endif
        repeat (4) @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
